onehot_scan_decoder: RTL and testbench

- Parametrised, registered binary-to-one-hot decoder: SEL_W select bits drive a 2^SEL_W-bit one-hot output.
- Two modes: direct (hold a loaded index) and scan (walking-one with programmable dwell, up/down direction, wrap pulse).
- Drives row/digit/channel strobes in multiplexed display and scan logic; replaces fixed 3-to-8 combinational decode where a registered, self-advancing strobe is needed.

---
 rtl/onehot_scan_decoder.sv | 177 +++++++++++++++++
 tb/tb_onehot_scan_decoder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/onehot_scan_decoder.sv
// onehot_scan_decoder
// Registered binary-to-one-hot strobe generator with two modes:
//   direct - hold a loaded index on the one-hot output
//   scan   - walking-one with programmable dwell, up/down direction and a
//            one-cycle wrap pulse when the index wraps around.
// Optional feature, enabled by defining SKIP_MASK_EN:
//   adds input skip_mask; scan advances jump to the nearest unmasked index
//   in the current direction, and a masked index never drives the output.
module onehot_scan_decoder #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     load,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     mode,
    input  logic                     run,
    input  logic                     dir,
    input  logic [DWELL_W-1:0]       dwell,
`ifdef SKIP_MASK_EN
    input  logic [(1<<SEL_W)-1:0]    skip_mask,
`endif
    output logic [(1<<SEL_W)-1:0]    out,
    output logic [SEL_W-1:0]         idx,
    output logic                     wrap,
    output logic                     busy
);

    localparam int OUT_W = 1 << SEL_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t               r_state;
    logic [SEL_W-1:0]     r_idx;
    logic [DWELL_W-1:0]   r_cnt;
    logic [OUT_W-1:0]     r_out;
    logic                 r_wrap;

    // Next scan position and whether moving there crosses the wrap boundary
    logic [SEL_W-1:0]     w_next_idx;
    logic                 w_next_wrap;
    logic                 w_found;

    // Decoded one-hot vectors
    logic [OUT_W-1:0]     w_sel_dec;
    logic [OUT_W-1:0]     w_adv_dec;
    logic [OUT_W-1:0]     w_cur_dec;
    logic [OUT_W-1:0]     w_sel_out;
    logic [OUT_W-1:0]     w_cur_out;

    // Position ends when the counter reaches (or has passed) the live dwell
    logic                 w_dwell_done;
    assign w_dwell_done = (r_cnt >= dwell);

    generate
        for (genvar gi = 0; gi < OUT_W; gi++) begin : g_dec
            assign w_sel_dec[gi] = (sel        == SEL_W'(gi));
            assign w_adv_dec[gi] = (w_next_idx == SEL_W'(gi));
            assign w_cur_dec[gi] = (r_idx      == SEL_W'(gi));
        end
    endgenerate

`ifdef SKIP_MASK_EN
    logic [SEL_W-1:0] w_cand;

    // A masked index never drives a strobe
    assign w_sel_out = w_sel_dec & ~skip_mask;
    assign w_cur_out = w_cur_dec & ~skip_mask;

    // Circular search for the nearest unmasked index in the scan direction;
    // iterating from the farthest distance down lets the nearest hit win.
    always_comb begin
        w_next_idx  = r_idx;
        w_next_wrap = 1'b0;
        w_found     = 1'b0;
        w_cand      = r_idx;
        for (int k = OUT_W; k >= 1; k--) begin
            if (dir) begin
                w_cand = r_idx - SEL_W'(k);
            end else begin
                w_cand = r_idx + SEL_W'(k);
            end
            if (!skip_mask[w_cand]) begin
                w_next_idx  = w_cand;
                w_found     = 1'b1;
                if (dir) begin
                    w_next_wrap = (k > int'(r_idx));
                end else begin
                    w_next_wrap = ((int'(r_idx) + k) >= OUT_W);
                end
            end
        end
    end
`else
    assign w_sel_out = w_sel_dec;
    assign w_cur_out = w_cur_dec;

    // Plain modulo step by one in the scan direction
    always_comb begin
        w_found = 1'b1;
        if (dir) begin
            w_next_idx  = r_idx - SEL_W'(1);
            w_next_wrap = (r_idx == '0);
        end else begin
            w_next_idx  = r_idx + SEL_W'(1);
            w_next_wrap = (r_idx == SEL_W'(OUT_W - 1));
        end
    end
`endif

    // Mode FSM: clr beats load, load beats a scan advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_wrap  <= 1'b0;
        end else if (clr) begin
            // idx deliberately retained across a clear
            r_state <= IDLE;
            r_cnt   <= '0;
            r_out   <= '0;
            r_wrap  <= 1'b0;
        end else if (load) begin
            r_state <= mode ? SCAN : HOLD;
            r_idx   <= sel;
            r_cnt   <= '0;
            r_out   <= w_sel_out;
            r_wrap  <= 1'b0;
        end else begin
            case (r_state)
                SCAN: begin
                    if (run) begin
                        if (w_dwell_done) begin
                            r_cnt <= '0;
                            if (w_found) begin
                                r_idx  <= w_next_idx;
                                r_out  <= w_adv_dec;
                                r_wrap <= w_next_wrap;
                            end else begin
                                // Nothing selectable: park index, dark output
                                r_out  <= '0;
                                r_wrap <= 1'b0;
                            end
                        end else begin
                            r_cnt  <= r_cnt + DWELL_W'(1);
                            r_out  <= w_cur_out;
                            r_wrap <= 1'b0;
                        end
                    end else begin
                        // Paused: everything frozen except the wrap pulse
                        r_wrap <= 1'b0;
                    end
                end
                default: begin
                    // IDLE and HOLD ignore run/dir/dwell
                    r_cnt  <= '0;
                    r_wrap <= 1'b0;
                end
            endcase
        end
    end

    assign out  = r_out;
    assign idx  = r_idx;
    assign wrap = r_wrap;
    // busy tracks the live run input so a pause shows up the same cycle
    assign busy = (r_state == SCAN) && run;

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Testbench for onehot_scan_decoder (SEL_W = 3, DWELL_W = 8).
// Expected values are pushed to a scoreboard queue when stimulus is driven
// and popped/compared once the DUT has taken the clock edge.
// Define SKIP_MASK_EN to also exercise the masked-scan build.
module tb_onehot_scan_decoder;

    localparam int SEL_W   = 3;
    localparam int DWELL_W = 8;
    localparam int OUT_W   = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               clr;
    logic               load;
    logic [SEL_W-1:0]   sel;
    logic               mode;
    logic               run;
    logic               dir;
    logic [DWELL_W-1:0] dwell;
`ifdef SKIP_MASK_EN
    logic [OUT_W-1:0]   skip_mask;
`endif
    logic [OUT_W-1:0]   out;
    logic [SEL_W-1:0]   idx;
    logic               wrap;
    logic               busy;

    onehot_scan_decoder #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .load      (load),
        .sel       (sel),
        .mode      (mode),
        .run       (run),
        .dir       (dir),
        .dwell     (dwell),
`ifdef SKIP_MASK_EN
        .skip_mask (skip_mask),
`endif
        .out       (out),
        .idx       (idx),
        .wrap      (wrap),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [SEL_W-1:0] idx;
        logic [OUT_W-1:0] out;
        logic             wrap;
        logic             busy;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Push the expectation for the coming edge, take the edge, compare
    task automatic step(input string tag, input int e_idx, input bit e_on,
                        input bit e_wrap, input bit e_busy);
        exp_t e;
        e.idx  = SEL_W'(e_idx);
        e.out  = e_on ? (OUT_W'(1) << e_idx) : '0;
        e.wrap = e_wrap;
        e.busy = e_busy;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        $display("%s: idx=%0d out=%b wrap=%b busy=%b", tag, idx, out, wrap, busy);
        check_eq({tag, ".idx"},  32'(idx),  32'(e.idx));
        check_eq({tag, ".out"},  32'(out),  32'(e.out));
        check_eq({tag, ".wrap"}, 32'(wrap), 32'(e.wrap));
        check_eq({tag, ".busy"}, 32'(busy), 32'(e.busy));
    endtask

    int up_seq[9]   = '{6, 6, 7, 7, 7, 0, 0, 0, 1};
    bit up_wrap[9]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0};

    initial begin
        rst_n = 1'b0; clr = 1'b0; load = 1'b0; sel = '0; mode = 1'b0;
        run = 1'b0; dir = 1'b0; dwell = '0;
`ifdef SKIP_MASK_EN
        skip_mask = '0;
`endif
        #12;
        check_eq("reset.out",  32'(out),  32'd0);
        check_eq("reset.idx",  32'(idx),  32'd0);
        check_eq("reset.wrap", 32'(wrap), 32'd0);
        check_eq("reset.busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        step("idle0", 0, 0, 0, 0);

        // Scan, then async reset mid-cycle
        load = 1'b1; sel = 3'd5; mode = 1'b1; run = 1'b1; dwell = 8'd0;
        step("rst_ld", 5, 1, 0, 1);
        load = 1'b0;
        step("rst_sc", 6, 1, 0, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("async.out",  32'(out),  32'd0);
        check_eq("async.idx",  32'(idx),  32'd0);
        check_eq("async.wrap", 32'(wrap), 32'd0);
        check_eq("async.busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst0", 0, 0, 0, 0);
        step("post_rst1", 0, 0, 0, 0);

        // Direct decode of every code; run toggling must not matter
        for (int s = 0; s < OUT_W; s++) begin
            load = 1'b1; sel = SEL_W'(s); mode = 1'b0; run = 1'($urandom_range(0, 1));
            step($sformatf("direct%0d", s), s, 1, 0, 0);
            load = 1'b0; run = ~run;
            step($sformatf("hold%0d", s), s, 1, 0, 0);
        end

        // Scan up, dwell 2, from 6 through the wrap
        load = 1'b1; sel = 3'd6; mode = 1'b1; run = 1'b1; dir = 1'b0; dwell = 8'd2;
        step("up_ld", 6, 1, 0, 1);
        load = 1'b0;
        for (int i = 0; i < 9; i++) step($sformatf("up%0d", i), up_seq[i], 1, up_wrap[i], 1);

        // Scan down, dwell 0, then pause and resume
        load = 1'b1; sel = 3'd1; dir = 1'b1; dwell = 8'd0;
        step("dn_ld", 1, 1, 0, 1);
        load = 1'b0;
        step("dn0", 0, 1, 0, 1);
        step("dn1", 7, 1, 1, 1);
        step("dn2", 6, 1, 0, 1);
        run = 1'b0;
        for (int i = 0; i < 3; i++) step($sformatf("pause%0d", i), 6, 1, 0, 0);
        run = 1'b1;
        step("resume", 5, 1, 0, 1);

        // clr beats load; idx retained
        clr = 1'b1; load = 1'b1; sel = 3'd3;
        step("clr_ld", 5, 0, 0, 0);
        clr = 1'b0; load = 1'b0;
        step("clr_idle", 5, 0, 0, 0);

        // Load mid-dwell restarts the count from the new index
        load = 1'b1; sel = 3'd2; dir = 1'b0; dwell = 8'd3;
        step("mid_ld", 2, 1, 0, 1);
        load = 1'b0;
        step("mid_c1", 2, 1, 0, 1);
        load = 1'b1; sel = 3'd4;
        step("reld", 4, 1, 0, 1);
        load = 1'b0;
        for (int i = 0; i < 3; i++) step($sformatf("reld_h%0d", i), 4, 1, 0, 1);
        step("reld_adv", 5, 1, 0, 1);

        // Shrinking dwell below the running count advances next cycle
        dwell = 8'd5;
        for (int i = 0; i < 3; i++) step($sformatf("dw_h%0d", i), 5, 1, 0, 1);
        dwell = 8'd1;
        step("dw_adv", 6, 1, 0, 1);
        step("dw_c1", 6, 1, 0, 1);
        step("dw_adv2", 7, 1, 0, 1);

`ifdef SKIP_MASK_EN
        // Masked scan: bits 1,2,5 skipped
        skip_mask = 8'b0010_0110;
        load = 1'b1; sel = 3'd0; mode = 1'b1; run = 1'b1; dir = 1'b0; dwell = 8'd0;
        step("mk_ld", 0, 1, 0, 1);
        load = 1'b0;
        step("mk0", 3, 1, 0, 1);
        step("mk1", 4, 1, 0, 1);
        step("mk2", 6, 1, 0, 1);
        step("mk3", 7, 1, 0, 1);
        step("mk4", 0, 1, 1, 1);
        skip_mask = 8'hFF;
        step("mk_all0", 0, 0, 0, 1);
        step("mk_all1", 0, 0, 0, 1);
        skip_mask = 8'b0000_0100;
        load = 1'b1; sel = 3'd2; mode = 1'b0;
        step("mk_ldm", 2, 0, 0, 0);
        load = 1'b0;
`endif

        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
